// File: rtl/uproc_core_p.sv
// uproc_core_p -- parametrised accumulator microprocessor core.
//
// Each instruction is fetched from external program memory and then executed in a
// separate cycle. The core has an accumulator, a carry flag, a register file and a
// data memory.
//
// Ports:
//   clk         in   rising-edge clock
//   nReset      in   asynchronous, active-low reset
//   imem_req    out  fetch request; held until imem_valid is seen
//   imem_addr   out  fetch address (the PC); stable while imem_req is high
//   imem_valid  in   imem_data valid; only sampled while imem_req is high
//   imem_data   in   instruction word {opcode[4:0], imm[DATA_WIDTH-1:0]}
//   accu        out  accumulator
//   carry       out  carry flag
//   retire      out  one-cycle pulse per executed instruction (HALT does not retire)
//   halted      out  core stopped by HALT; only reset leaves this state
//
// Optional build macro UPROC_TRACE_EN adds trace_pc / trace_ins. These hold the
// PC and instruction of the retiring instruction during the retire cycle, and
// keep their value at all other times.
module uproc_core_p #(
  parameter int DATA_WIDTH     = 8,
  parameter int PC_WIDTH       = 6,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DMEM_AW        = 6
) (
  input  logic                  clk,
  input  logic                  nReset,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH+4:0] imem_data,
  output logic [DATA_WIDTH-1:0] accu,
  output logic                  carry,
  output logic                  retire,
  output logic                  halted
`ifdef UPROC_TRACE_EN
  ,
  output logic [PC_WIDTH-1:0]   trace_pc,
  output logic [DATA_WIDTH+4:0] trace_ins
`endif
);

  localparam int INS_WIDTH  = DATA_WIDTH + 5;
  localparam int RF_DEPTH   = 1 << REG_ADDR_WIDTH;
  localparam int DMEM_DEPTH = 1 << DMEM_AW;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_LDR  = 5'b00010;
  localparam logic [4:0] OP_LDM  = 5'b00011;
  localparam logic [4:0] OP_STR  = 5'b00100;
  localparam logic [4:0] OP_STM  = 5'b00101;
  localparam logic [4:0] OP_ADDI = 5'b00110;
  localparam logic [4:0] OP_ADD  = 5'b00111;
  localparam logic [4:0] OP_ADC  = 5'b01000;
  localparam logic [4:0] OP_SUB  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_JMP  = 5'b01101;
  localparam logic [4:0] OP_JC   = 5'b01110;
  localparam logic [4:0] OP_JZ   = 5'b01111;
  localparam logic [4:0] OP_CLRC = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b10001;

  logic [1:0]            state_r;
  logic [PC_WIDTH-1:0]   pc_r;
  logic [INS_WIDTH-1:0]  ir_r;
  logic [DATA_WIDTH-1:0] accu_r;
  logic                  carry_r;
  logic                  req_r;
  logic                  retire_r;
  logic                  halted_r;
  logic [DATA_WIDTH-1:0] rf_r   [RF_DEPTH];
  logic [DATA_WIDTH-1:0] dmem_r [DMEM_DEPTH];

  logic [4:0]                opcode_s;
  logic [DATA_WIDTH-1:0]     imm_s;
  logic [REG_ADDR_WIDTH-1:0] rf_idx_s;
  logic [DMEM_AW-1:0]        dm_idx_s;
  logic [DATA_WIDTH-1:0]     rf_rd_s;
  logic [DATA_WIDTH-1:0]     dm_rd_s;
  logic [DATA_WIDTH-1:0]     add_b_s;
  logic                      cin_s;
  logic [DATA_WIDTH:0]       sum_s;
  logic [DATA_WIDTH-1:0]     accu_nx_s;
  logic                      carry_nx_s;
  logic [PC_WIDTH-1:0]       pc_inc_s;
  logic [PC_WIDTH-1:0]       pc_nx_s;
  logic                      rf_we_s;
  logic                      dm_we_s;
  logic                      fetch_halt_s;

  // Decode fields of the held instruction; register and memory reads are combinational.
  assign opcode_s     = ir_r[INS_WIDTH-1 -: 5];
  assign imm_s        = ir_r[DATA_WIDTH-1:0];
  assign rf_idx_s     = imm_s[REG_ADDR_WIDTH-1:0];
  assign dm_idx_s     = imm_s[DMEM_AW-1:0];
  assign rf_rd_s      = rf_r[rf_idx_s];
  assign dm_rd_s      = dmem_r[dm_idx_s];
  assign pc_inc_s     = pc_r + PC_WIDTH'(1);
  assign fetch_halt_s = (imem_data[INS_WIDTH-1 -: 5] == OP_HALT);

  // Adder operand select: SUB uses A + ~R + 1, so carry=1 means no borrow.
  always_comb begin
    add_b_s = rf_rd_s;
    cin_s   = 1'b0;
    case (opcode_s)
      OP_ADDI: begin add_b_s = imm_s;    cin_s = 1'b0;    end
      OP_ADC:  begin add_b_s = rf_rd_s;  cin_s = carry_r; end
      OP_SUB:  begin add_b_s = ~rf_rd_s; cin_s = 1'b1;    end
      default: begin add_b_s = rf_rd_s;  cin_s = 1'b0;    end
    endcase
  end

  assign sum_s = {1'b0, accu_r} + {1'b0, add_b_s} + {{DATA_WIDTH{1'b0}}, cin_s};

  // Next architectural state computed from the held instruction.
  always_comb begin
    accu_nx_s  = accu_r;
    carry_nx_s = carry_r;
    pc_nx_s    = pc_inc_s;
    rf_we_s    = 1'b0;
    dm_we_s    = 1'b0;
    case (opcode_s)
      OP_LDI:  accu_nx_s = imm_s;
      OP_LDR:  accu_nx_s = rf_rd_s;
      OP_LDM:  accu_nx_s = dm_rd_s;
      OP_STR:  rf_we_s   = 1'b1;
      OP_STM:  dm_we_s   = 1'b1;
      OP_ADDI, OP_ADD, OP_ADC, OP_SUB: {carry_nx_s, accu_nx_s} = sum_s;
      OP_AND:  accu_nx_s = accu_r & rf_rd_s;
      OP_OR:   accu_nx_s = accu_r | rf_rd_s;
      OP_XOR:  accu_nx_s = accu_r ^ rf_rd_s;
      OP_JMP:  pc_nx_s   = imm_s[PC_WIDTH-1:0];
      OP_JC: begin
        if (carry_r) pc_nx_s = imm_s[PC_WIDTH-1:0];
        else         pc_nx_s = pc_inc_s;
      end
      // The zero test uses the accumulator value from before this instruction.
      OP_JZ: begin
        if (accu_r == '0) pc_nx_s = imm_s[PC_WIDTH-1:0];
        else              pc_nx_s = pc_inc_s;
      end
      OP_CLRC: carry_nx_s = 1'b0;
      OP_HALT: pc_nx_s    = pc_r;
      default: pc_nx_s    = pc_inc_s;
    endcase
  end

  // Fetch/execute sequencer. After reset, imem_req is low for one cycle before the first fetch.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r  <= S_FETCH;
      pc_r     <= '0;
      ir_r     <= '0;
      accu_r   <= '0;
      carry_r  <= 1'b0;
      req_r    <= 1'b0;
      retire_r <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (!req_r) begin
            req_r <= 1'b1;
          end else if (imem_valid) begin
            ir_r     <= imem_data;
            req_r    <= 1'b0;
            retire_r <= !fetch_halt_s;
            state_r  <= S_EXEC;
          end
        end
        S_EXEC: begin
          accu_r   <= accu_nx_s;
          carry_r  <= carry_nx_s;
          pc_r     <= pc_nx_s;
          retire_r <= 1'b0;
          if (opcode_s == OP_HALT) begin
            halted_r <= 1'b1;
            state_r  <= S_HALTED;
          end else begin
            req_r   <= 1'b1;
            state_r <= S_FETCH;
          end
        end
        S_HALTED: begin
          req_r    <= 1'b0;
          retire_r <= 1'b0;
        end
        default: begin
          state_r <= S_FETCH;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // Register file: cleared on reset, written from the accumulator by STR.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_r[i] <= '0;
    end else if (state_r == S_EXEC && rf_we_s) begin
      rf_r[rf_idx_s] <= accu_r;
    end
  end

  // Data memory: cleared on reset, written from the accumulator by STM.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_r[i] <= '0;
    end else if (state_r == S_EXEC && dm_we_s) begin
      dmem_r[dm_idx_s] <= accu_r;
    end
  end

`ifdef UPROC_TRACE_EN
  logic [PC_WIDTH-1:0]  trace_pc_r;
  logic [INS_WIDTH-1:0] trace_ins_r;

  // Trace capture happens at the accept edge, so the values line up with the retire pulse.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      trace_pc_r  <= '0;
      trace_ins_r <= '0;
    end else if (state_r == S_FETCH && req_r && imem_valid && !fetch_halt_s) begin
      trace_pc_r  <= pc_r;
      trace_ins_r <= imem_data;
    end
  end

  assign trace_pc  = trace_pc_r;
  assign trace_ins = trace_ins_r;
`endif

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign accu      = accu_r;
  assign carry     = carry_r;
  assign retire    = retire_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_uproc_core_p.sv
module tb_uproc_core_p;

  logic        clk = 1'b0;
  logic        nReset;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_valid;
  logic [12:0] imem_data;
  logic [7:0]  accu;
  logic        carry;
  logic        retire;
  logic        halted;
`ifdef UPROC_TRACE_EN
  logic [5:0]  trace_pc;
  logic [12:0] trace_ins;
`endif

  uproc_core_p dut (
    .clk        (clk),
    .nReset     (nReset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .accu       (accu),
    .carry      (carry),
    .retire     (retire),
    .halted     (halted)
`ifdef UPROC_TRACE_EN
    ,
    .trace_pc   (trace_pc),
    .trace_ins  (trace_ins)
`endif
  );

  always #5 clk = ~clk;

  // Program memory and the instruction-level reference model state.
  logic [12:0] prog [64];
  logic [7:0]  m_rf [16];
  logic [7:0]  m_dm [64];
  logic [7:0]  m_a;
  logic        m_c;
  logic [5:0]  m_pc;
  logic        m_halt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_ret   = 0;

  // Free-running cycle counter and retire-pulse counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (retire === 1'b1) n_ret <= n_ret + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ins(input logic [4:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 13'd0;
  endtask

  // Architectural meaning of one instruction, using plain integer arithmetic.
  task automatic model_exec(input logic [12:0] iw);
    logic [4:0] op;
    logic [7:0] imm;
    int a, r, s;
    logic [5:0] npc;
    op  = iw[12:8];
    imm = iw[7:0];
    a   = int'(m_a);
    r   = int'(m_rf[imm[3:0]]);
    npc = m_pc + 6'd1;
    case (op)
      5'd1:  m_a = imm;
      5'd2:  m_a = m_rf[imm[3:0]];
      5'd3:  m_a = m_dm[imm[5:0]];
      5'd4:  m_rf[imm[3:0]] = m_a;
      5'd5:  m_dm[imm[5:0]] = m_a;
      5'd6:  begin s = a + int'(imm);      m_a = 8'(s % 256); m_c = (s > 255); end
      5'd7:  begin s = a + r;              m_a = 8'(s % 256); m_c = (s > 255); end
      5'd8:  begin s = a + r + int'(m_c);  m_a = 8'(s % 256); m_c = (s > 255); end
      5'd9:  begin m_a = 8'((a - r + 256) % 256); m_c = (a >= r); end
      5'd10: m_a = m_a & m_rf[imm[3:0]];
      5'd11: m_a = m_a | m_rf[imm[3:0]];
      5'd12: m_a = m_a ^ m_rf[imm[3:0]];
      5'd13: npc = imm[5:0];
      5'd14: if (m_c) npc = imm[5:0];
      5'd15: if (a == 0) npc = imm[5:0];
      5'd16: m_c = 1'b0;
      5'd17: begin m_halt = 1'b1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic do_reset();
    nReset     = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 13'd0;
    @(negedge clk);
    @(negedge clk);
    m_a = 8'd0; m_c = 1'b0; m_pc = 6'd0; m_halt = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = 8'd0;
    for (int i = 0; i < 64; i++) m_dm[i] = 8'd0;
    nReset = 1'b1;
  endtask

  // One instruction: wait for the request, insert wait states, deliver, check execution.
  // With noise set, imem_valid is also toggled at points where the core must ignore it.
  task automatic step(input int waits, input bit noise, output int exec_cyc);
    int n;
    logic [12:0] iw;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      imem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_data  = 13'($urandom);
      @(negedge clk);
      n++;
    end
    imem_valid = 1'b0;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'(m_pc));
    end
    iw = prog[m_pc];
    imem_valid = 1'b1;
    imem_data  = iw;
    @(negedge clk);
    exec_cyc   = cyc;
    imem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    imem_data  = 13'($urandom);
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("retire", 32'(retire), 32'(iw[12:8] != 5'd17));
`ifdef UPROC_TRACE_EN
    if (iw[12:8] != 5'd17) begin
      chk("trace_pc", 32'(trace_pc), 32'(m_pc));
      chk("trace_ins", 32'(trace_ins), 32'(iw));
    end
`endif
    model_exec(iw);
    @(negedge clk);
    imem_valid = 1'b0;
    chk("accu", 32'(accu), 32'(m_a));
    chk("carry", 32'(carry), 32'(m_c));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  initial begin
    int c0, c1, c2, r0;
    nReset = 1'b0;
    imem_valid = 1'b0;
    imem_data = 13'd0;
    clear_prog();

    // Reset state, sampled while nReset is held low.
    do_reset();
    nReset = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_accu", 32'(accu), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // 1: LDI 5; ADDI 3; HALT with no wait states.
    clear_prog();
    prog[0] = ins(5'd1, 8'd5);
    prog[1] = ins(5'd6, 8'd3);
    prog[2] = ins(5'd17, 8'd0);
    do_reset();
    r0 = n_ret;
    step(0, 1'b0, c0); step(0, 1'b0, c1); step(0, 1'b0, c2);
    repeat (3) @(negedge clk);
    chk("t1_accu", 32'(accu), 32'd8);
    chk("t1_carry", 32'(carry), 32'd0);
    chk("t1_retires", 32'(n_ret - r0), 32'd2);
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_req", 32'(imem_req), 32'd0);

    // 2: LDI 0xFF; ADDI 1 wraps and sets carry; JC 0 is taken.
    clear_prog();
    prog[0] = ins(5'd1, 8'hFF);
    prog[1] = ins(5'd6, 8'h01);
    prog[2] = ins(5'd14, 8'h00);
    do_reset();
    step(0, 1'b0, c0); step(0, 1'b0, c0);
    chk("t2_accu", 32'(accu), 32'h00);
    chk("t2_carry", 32'(carry), 32'd1);
    step(0, 1'b0, c0);
    chk("t2_jc_target", 32'(imem_addr), 32'd0);

    // 3: register file and data memory round trip.
    clear_prog();
    prog[0] = ins(5'd1, 8'h3C);
    prog[1] = ins(5'd4, 8'd2);
    prog[2] = ins(5'd1, 8'd0);
    prog[3] = ins(5'd2, 8'd2);
    prog[4] = ins(5'd5, 8'd63);
    prog[5] = ins(5'd1, 8'd0);
    prog[6] = ins(5'd3, 8'd63);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1'b0, c0);
    chk("t3_ldr", 32'(accu), 32'h3C);
    for (int i = 0; i < 3; i++) step(0, 1'b0, c0);
    chk("t3_ldm", 32'(accu), 32'h3C);

    // 4: three wait states per fetch, retire spacing of five cycles.
    clear_prog();
    prog[0] = ins(5'd1, 8'd5);
    prog[1] = ins(5'd6, 8'd3);
    prog[2] = ins(5'd17, 8'd0);
    do_reset();
    step(3, 1'b0, c0); step(3, 1'b0, c1); step(3, 1'b0, c2);
    chk("t4_retire_period", 32'(c1 - c0), 32'd5);
    chk("t4_exec_period", 32'(c2 - c1), 32'd5);
    chk("t4_accu", 32'(accu), 32'd8);
    chk("t4_halted", 32'(halted), 32'd1);

    // 5: JZ taken at zero, JMP 63 then wrap to 0, JZ not taken, SUB R0.
    clear_prog();
    prog[0]  = ins(5'd15, 8'd2);
    prog[1]  = ins(5'd9, 8'd0);
    prog[2]  = ins(5'd1, 8'd4);
    prog[3]  = ins(5'd13, 8'd63);
    prog[63] = ins(5'd0, 8'd0);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1'b0, c0);
    chk("t5_wrap_addr", 32'(imem_addr), 32'd0);
    step(0, 1'b0, c0);
    chk("t5_jz_not_taken", 32'(imem_addr), 32'd1);
    step(0, 1'b0, c0);
    chk("t5_sub_accu", 32'(accu), 32'd4);
    chk("t5_sub_carry", 32'(carry), 32'd1);

    // 6: reset pulse during a wait state clears everything.
    clear_prog();
    prog[0] = ins(5'd1, 8'h55);
    prog[1] = ins(5'd4, 8'd3);
    prog[2] = ins(5'd5, 8'd7);
    prog[3] = ins(5'd6, 8'd1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1'b0, c0);
    @(negedge clk);
    chk("t6_req_before", 32'(imem_req), 32'd1);
    #2 nReset = 1'b0;
    #1;
    chk("t6_req_async", 32'(imem_req), 32'd0);
    chk("t6_retire_async", 32'(retire), 32'd0);
    chk("t6_accu_async", 32'(accu), 32'd0);
    prog[0] = ins(5'd2, 8'd3);
    prog[1] = ins(5'd3, 8'd7);
    do_reset();
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_carry", 32'(carry), 32'd0);
    step(0, 1'b0, c0);
    chk("t6_rf_cleared", 32'(accu), 32'd0);
    step(0, 1'b0, c0);
    chk("t6_dmem_cleared", 32'(accu), 32'd0);

    // Random programs with random wait states and stray imem_valid pulses.
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 64; i++) begin
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd17) op = 5'd6;
        prog[i] = ins(op, 8'($urandom));
      end
      do_reset();
      for (int k = 0; k < 40; k++) step($urandom_range(0, 2), 1'b1, c0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
